imem_load_fetch_ctrl: RTL and testbench
=======================================

// Module: imem_load_fetch_ctrl
// PURPOSE
//  Controller in front of the 32-bit instruction memory: sequences program load, then serves CPU fetches.
//  Arbitrates the single memory port between loader writes (LOAD) and PC fetches (RUN).
//  Sits between the boot loader, the fetch stage and the instruction memory array.
// PARAMETERS
//  DEPTH  64                 instruction words in memory
//  AW     $clog2(DEPTH)      word-address width
//  XLEN   32                 instruction/data width
// PORTS
//  clk          in   1     single clock, all logic on posedge
//  reset        in   1     synchronous, active-high
//  load_start   in   1     pulse: (re)enter LOAD, write pointer cleared
//  ld_valid     in   1     loader word valid
//  ld_ready     out  1     controller accepts loader word
//  ld_data      in   XLEN  instruction word to store
//  ld_last      in   1     qualifies final word of program
//  fetch_valid  in   1     fetch request valid
//  fetch_ready  out  1     fetch request accepted
//  fetch_addr   in   32    byte address (PC)
//  rsp_valid    out  1     instruction response valid (no backpressure)
//  rsp_instr    out  XLEN  fetched instruction
//  rsp_err      out  1     fetch fault (constant 0 unless IMEM_ALIGN_CHECK_EN)
//  cpu_run      out  1     high in RUN; gates the core
//  load_count   out  AW+1  words written in current/last load
//  mem_en       out  1     memory access strobe
//  mem_we       out  1     memory write enable
//  mem_addr     out  AW    memory word address
//  mem_wdata    out  XLEN  memory write data
//  mem_rdata    in   XLEN  memory read data, valid 1 cycle after mem_en & !mem_we
// BEHAVIOUR
//  States IDLE, LOAD, RUN. Reset -> IDLE; rsp_valid, rsp_instr, rsp_err, cpu_run, load_count, mem_* all 0.
//  IDLE: ld_ready=0, fetch_ready=0; load_start -> LOAD, load_count<=0.
//  LOAD: ld_ready = !load_start. Accept (ld_valid&ld_ready) -> mem_en=mem_we=1, mem_addr=load_count[AW-1:0],
//   mem_wdata=ld_data, same cycle (combinational); load_count++.
//   Accepted word with ld_last=1, or accepted word making load_count==DEPTH -> RUN next cycle.
//   load_start in LOAD: no write that cycle, load_count<=0, stay LOAD (restart).
//  RUN: cpu_run=1; fetch_ready = !load_start. Accept -> mem_en=1, mem_we=0, mem_addr=fetch_addr[AW+1:2].
//   Latency 1: rsp_valid=1 cycle after accept, rsp_instr=mem_rdata; one fetch/cycle, back-to-back allowed.
//   fetch_addr bits [1:0] and above AW+1 ignored (index wraps modulo DEPTH).
//   load_start in RUN: no fetch accepted; response of fetch accepted prior cycle still delivered;
//   -> LOAD next cycle, cpu_run=0, load_count<=0.
//  rsp_instr holds last value when rsp_valid=0. Loader and fetch never share a cycle (state-exclusive).
//  Reset mid-load: -> IDLE, pending response dropped; memory contents untouched by controller.
// CONFIGURATION
//  IMEM_ALIGN_CHECK_EN defined: fetch with fetch_addr[1:0]!=0 or fetch_addr >= DEPTH*4 is accepted but
//   no memory read (mem_en=0); next cycle rsp_valid=1, rsp_instr=32'h0000_0013 (NOP), rsp_err=1.
//   Legal fetches give rsp_err=0.
//  Not defined: no checks, wrap as above, rsp_err tied 0.
// STRUCTURE
//  Package imem_ctrl_pkg: typedef enum logic [1:0] {IMEM_IDLE, IMEM_LOAD, IMEM_RUN} imem_state_e;
//   localparam NOP_INSTR = 32'h0000_0013; XLEN default.
//  Single module, no sub-module; memory array instantiated outside, driven via mem_* ports.
// TESTING
//  reset held 3 cycles -> cpu_run=0, ld_ready=0, fetch_ready=0, rsp_valid=0, load_count=0.
//  load_start, 4 words A0..A3 with ld_last on A3 -> mem writes addr 0..3, load_count=4, cpu_run=1 next cycle.
//  RUN, fetch 0x0,0x4,0x8 back-to-back -> rsp_valid 3 consecutive cycles, rsp_instr A0,A1,A2.
//  64 words without ld_last -> auto RUN after word 63, load_count=64; 65th ld_valid not accepted.
//  RUN, fetch 0x4 then load_start next cycle -> A1 response delivered, fetch_ready=0, LOAD, cpu_run=0.
//  IMEM_ALIGN_CHECK_EN: fetch 0x6 and 0x100 -> mem_en=0, rsp_instr=0x00000013, rsp_err=1; without: 0x100 returns A0.

Source files
------------

// File: rtl/imem_ctrl_pkg.sv
// Shared types and constants for the instruction-memory load/fetch controller.
package imem_ctrl_pkg;

   typedef enum logic [1:0] {
      IMEM_IDLE,
      IMEM_LOAD,
      IMEM_RUN
   } imem_state_e;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   localparam int unsigned IMEM_XLEN = 32;

endpackage

// File: rtl/imem_load_fetch_ctrl.sv
// Owns the single instruction-memory port: loader writes in LOAD, PC fetches in RUN.
// Optional IMEM_ALIGN_CHECK_EN turns misaligned/out-of-range fetches into faulting NOP responses.
module imem_load_fetch_ctrl
   import imem_ctrl_pkg::*;
#(
   parameter int unsigned DEPTH = 64,
   parameter int unsigned AW    = $clog2(DEPTH),
   parameter int unsigned XLEN  = IMEM_XLEN
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            load_start,
   input  logic            ld_valid,
   output logic            ld_ready,
   input  logic [XLEN-1:0] ld_data,
   input  logic            ld_last,
   input  logic            fetch_valid,
   output logic            fetch_ready,
   input  logic [31:0]     fetch_addr,
   output logic            rsp_valid,
   output logic [XLEN-1:0] rsp_instr,
   output logic            rsp_err,
   output logic            cpu_run,
   output logic [AW:0]     load_count,
   output logic            mem_en,
   output logic            mem_we,
   output logic [AW-1:0]   mem_addr,
   output logic [XLEN-1:0] mem_wdata,
   input  logic [XLEN-1:0] mem_rdata
);

   imem_state_e     state_q, state_d;
   logic [AW:0]     load_count_q, load_count_d;
   logic            rsp_valid_q;
   logic            err_q;
   logic [XLEN-1:0] rsp_hold_q;
   logic            fetch_accept;
   logic            fetch_bad;

`ifdef IMEM_ALIGN_CHECK_EN
   assign fetch_bad = (fetch_addr[1:0] != 2'b00) || (fetch_addr >= 32'(DEPTH * 4));
`else
   assign fetch_bad = 1'b0;
`endif

   // Address bits outside the word index are intentionally ignored in the default build.
   logic unused_addr;
   assign unused_addr = ^{fetch_addr[1:0], fetch_addr[31:AW+2]};

   always_comb begin
      state_d      = state_q;
      load_count_d = load_count_q;
      ld_ready     = 1'b0;
      fetch_ready  = 1'b0;
      fetch_accept = 1'b0;
      mem_en       = 1'b0;
      mem_we       = 1'b0;
      mem_addr     = '0;
      mem_wdata    = '0;
      case (state_q)
         IMEM_IDLE: begin
            if (load_start) begin
               state_d      = IMEM_LOAD;
               load_count_d = '0;
            end
         end
         IMEM_LOAD: begin
            ld_ready = !load_start;
            if (load_start) begin
               load_count_d = '0;
            end else if (ld_valid) begin
               mem_en       = 1'b1;
               mem_we       = 1'b1;
               mem_addr     = load_count_q[AW-1:0];
               mem_wdata    = ld_data;
               load_count_d = load_count_q + 1'b1;
               if (ld_last || (load_count_d == (AW+1)'(DEPTH))) begin
                  state_d = IMEM_RUN;
               end
            end
         end
         IMEM_RUN: begin
            fetch_ready = !load_start;
            if (load_start) begin
               state_d      = IMEM_LOAD;
               load_count_d = '0;
            end else if (fetch_valid) begin
               fetch_accept = 1'b1;
               mem_en       = !fetch_bad;
               mem_addr     = fetch_addr[AW+1:2];
            end
         end
         default: state_d = IMEM_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IMEM_IDLE;
         load_count_q <= '0;
         rsp_valid_q  <= 1'b0;
         err_q        <= 1'b0;
         rsp_hold_q   <= '0;
      end else begin
         state_q      <= state_d;
         load_count_q <= load_count_d;
         rsp_valid_q  <= fetch_accept;
         err_q        <= fetch_accept & fetch_bad;
         if (rsp_valid_q) begin
            rsp_hold_q <= rsp_instr;
         end
      end
   end

   // Read data arrives straight from the array in the response cycle; hold it afterwards.
   always_comb begin
      if (!rsp_valid_q) begin
         rsp_instr = rsp_hold_q;
      end else if (err_q) begin
         rsp_instr = XLEN'(NOP_INSTR);
      end else begin
         rsp_instr = mem_rdata;
      end
   end

`ifdef IMEM_ALIGN_CHECK_EN
   assign rsp_err = rsp_valid_q & err_q;
`else
   assign rsp_err = 1'b0;
`endif

   assign rsp_valid  = rsp_valid_q;
   assign cpu_run    = (state_q == IMEM_RUN);
   assign load_count = load_count_q;

endmodule

// File: tb/tb_imem_load_fetch_ctrl.sv
// Directed bench for imem_load_fetch_ctrl with a behavioural 64-word memory on the mem_* port.
module tb_imem_load_fetch_ctrl;

   localparam int unsigned DEPTH = 64;
   localparam int unsigned AW    = 6;

   logic          clk = 1'b0;
   logic          reset;
   logic          load_start;
   logic          ld_valid;
   logic          ld_ready;
   logic [31:0]   ld_data;
   logic          ld_last;
   logic          fetch_valid;
   logic          fetch_ready;
   logic [31:0]   fetch_addr;
   logic          rsp_valid;
   logic [31:0]   rsp_instr;
   logic          rsp_err;
   logic          cpu_run;
   logic [AW:0]   load_count;
   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic [31:0]   mem_rdata;

   logic [31:0] mem [DEPTH];

   int pass_cnt  = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   imem_load_fetch_ctrl #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .load_start (load_start),
      .ld_valid   (ld_valid),
      .ld_ready   (ld_ready),
      .ld_data    (ld_data),
      .ld_last    (ld_last),
      .fetch_valid(fetch_valid),
      .fetch_ready(fetch_ready),
      .fetch_addr (fetch_addr),
      .rsp_valid  (rsp_valid),
      .rsp_instr  (rsp_instr),
      .rsp_err    (rsp_err),
      .cpu_run    (cpu_run),
      .load_count (load_count),
      .mem_en     (mem_en),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         else        mem_rdata <= mem[mem_addr];
      end
   end

   function automatic logic [31:0] a_word(input int i);
      return 32'hA0A0_0000 | 32'(i);
   endfunction

   function automatic logic [31:0] b_word(input int i);
      return 32'hB00B_0000 | 32'(i);
   endfunction

   task automatic test_reset();
      reset = 1'b1;
      load_start = 1'b0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
      fetch_valid = 1'b0; fetch_addr = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total_cnt++;
      if (cpu_run !== 1'b0) $display("FAIL reset_cpu_run got %b want 0", cpu_run);
      else pass_cnt++;
      total_cnt++;
      if (ld_ready !== 1'b0 || fetch_ready !== 1'b0)
         $display("FAIL reset_ready got ld=%b fetch=%b want 0/0", ld_ready, fetch_ready);
      else pass_cnt++;
      total_cnt++;
      if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_instr !== 32'h0)
         $display("FAIL reset_rsp got v=%b e=%b i=%h want 0/0/0", rsp_valid, rsp_err, rsp_instr);
      else pass_cnt++;
      total_cnt++;
      if (load_count !== 7'd0 || mem_en !== 1'b0 || mem_we !== 1'b0)
         $display("FAIL reset_count_mem got cnt=%0d en=%b we=%b want 0/0/0",
                  load_count, mem_en, mem_we);
      else pass_cnt++;
      reset = 1'b0;
   endtask

   task automatic test_load4();
      load_start = 1'b1;
      @(negedge clk);
      load_start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         ld_valid = 1'b1; ld_data = a_word(i); ld_last = (i == 3);
         #1;
         total_cnt++;
         if (ld_ready !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b1 ||
             mem_addr !== 6'(i) || mem_wdata !== a_word(i))
            $display("FAIL load4_write%0d got rdy=%b en=%b we=%b addr=%0d data=%h want 1/1/1/%0d/%h",
                     i, ld_ready, mem_en, mem_we, mem_addr, mem_wdata, i, a_word(i));
         else pass_cnt++;
         @(negedge clk);
      end
      ld_valid = 1'b0; ld_last = 1'b0;
      total_cnt++;
      if (load_count !== 7'd4 || cpu_run !== 1'b1)
         $display("FAIL load4_done got cnt=%0d run=%b want 4/1", load_count, cpu_run);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 3; i++) begin
         fetch_valid = 1'b1; fetch_addr = 32'(i * 4);
         #1;
         total_cnt++;
         if (fetch_ready !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 6'(i))
            $display("FAIL b2b_req%0d got rdy=%b en=%b we=%b addr=%0d want 1/1/0/%0d",
                     i, fetch_ready, mem_en, mem_we, mem_addr, i);
         else pass_cnt++;
         @(negedge clk);
         total_cnt++;
         if (rsp_valid !== 1'b1 || rsp_instr !== a_word(i))
            $display("FAIL b2b_rsp%0d got v=%b instr=%h want 1/%h", i, rsp_valid, rsp_instr, a_word(i));
         else pass_cnt++;
      end
      fetch_valid = 1'b0;
      @(negedge clk);
      total_cnt++;
      if (rsp_valid !== 1'b0 || rsp_instr !== a_word(2))
         $display("FAIL b2b_hold got v=%b instr=%h want 0/%h", rsp_valid, rsp_instr, a_word(2));
      else pass_cnt++;
   endtask

   task automatic test_fetch_then_load();
      fetch_valid = 1'b1; fetch_addr = 32'h4;
      @(negedge clk);
      load_start = 1'b1;
      #1;
      total_cnt++;
      if (fetch_ready !== 1'b0 || mem_en !== 1'b0)
         $display("FAIL fl_blocked got rdy=%b en=%b want 0/0", fetch_ready, mem_en);
      else pass_cnt++;
      total_cnt++;
      if (rsp_valid !== 1'b1 || rsp_instr !== a_word(1) || cpu_run !== 1'b1)
         $display("FAIL fl_rsp got v=%b instr=%h run=%b want 1/%h/1",
                  rsp_valid, rsp_instr, cpu_run, a_word(1));
      else pass_cnt++;
      @(negedge clk);
      load_start = 1'b0; fetch_valid = 1'b0;
      #1;
      total_cnt++;
      if (cpu_run !== 1'b0 || ld_ready !== 1'b1 || load_count !== 7'd0 || rsp_valid !== 1'b0)
         $display("FAIL fl_load got run=%b ldrdy=%b cnt=%0d v=%b want 0/1/0/0",
                  cpu_run, ld_ready, load_count, rsp_valid);
      else pass_cnt++;
   endtask

   task automatic test_restart();
      for (int i = 0; i < 2; i++) begin
         ld_valid = 1'b1; ld_data = 32'hDEAD_0000 | 32'(i); ld_last = 1'b0;
         @(negedge clk);
      end
      load_start = 1'b1;
      #1;
      total_cnt++;
      if (ld_ready !== 1'b0 || mem_en !== 1'b0 || load_count !== 7'd2)
         $display("FAIL restart_block got rdy=%b en=%b cnt=%0d want 0/0/2", ld_ready, mem_en, load_count);
      else pass_cnt++;
      @(negedge clk);
      load_start = 1'b0; ld_data = 32'hC0DE_0001; ld_last = 1'b1;
      #1;
      total_cnt++;
      if (load_count !== 7'd0 || mem_addr !== 6'd0 || mem_en !== 1'b1)
         $display("FAIL restart_addr got cnt=%0d addr=%0d en=%b want 0/0/1", load_count, mem_addr, mem_en);
      else pass_cnt++;
      @(negedge clk);
      ld_valid = 1'b0; ld_last = 1'b0;
      total_cnt++;
      if (cpu_run !== 1'b1 || load_count !== 7'd1)
         $display("FAIL restart_run got run=%b cnt=%0d want 1/1", cpu_run, load_count);
      else pass_cnt++;
   endtask

   task automatic test_load64();
      load_start = 1'b1;
      @(negedge clk);
      load_start = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         ld_valid = 1'b1; ld_data = b_word(i); ld_last = 1'b0;
         #1;
         total_cnt++;
         if (ld_ready !== 1'b1 || mem_en !== 1'b1 || mem_addr !== 6'(i) || cpu_run !== 1'b0)
            $display("FAIL load64_w%0d got rdy=%b en=%b addr=%0d run=%b want 1/1/%0d/0",
                     i, ld_ready, mem_en, mem_addr, cpu_run, i);
         else pass_cnt++;
         @(negedge clk);
      end
      #1;
      total_cnt++;
      if (cpu_run !== 1'b1 || load_count !== 7'd64)
         $display("FAIL load64_done got run=%b cnt=%0d want 1/64", cpu_run, load_count);
      else pass_cnt++;
      total_cnt++;
      if (ld_ready !== 1'b0 || mem_we !== 1'b0)
         $display("FAIL load64_extra got rdy=%b we=%b want 0/0", ld_ready, mem_we);
      else pass_cnt++;
      ld_valid = 1'b0;
   endtask

   task automatic test_addr_check();
      logic [31:0] addrs [2];
      addrs[0] = 32'h6;
      addrs[1] = 32'h100;
      for (int i = 0; i < 2; i++) begin
         fetch_valid = 1'b1; fetch_addr = addrs[i];
         #1;
`ifdef IMEM_ALIGN_CHECK_EN
         total_cnt++;
         if (fetch_ready !== 1'b1 || mem_en !== 1'b0)
            $display("FAIL chk_req%0d got rdy=%b en=%b want 1/0", i, fetch_ready, mem_en);
         else pass_cnt++;
         @(negedge clk);
         total_cnt++;
         if (rsp_valid !== 1'b1 || rsp_instr !== 32'h0000_0013 || rsp_err !== 1'b1)
            $display("FAIL chk_rsp%0d got v=%b instr=%h err=%b want 1/00000013/1",
                     i, rsp_valid, rsp_instr, rsp_err);
         else pass_cnt++;
`else
         // 0x6 -> word 1, 0x100 wraps to word 0.
         total_cnt++;
         if (fetch_ready !== 1'b1 || mem_en !== 1'b1 || mem_addr !== ((i == 0) ? 6'd1 : 6'd0))
            $display("FAIL wrap_req%0d got rdy=%b en=%b addr=%0d", i, fetch_ready, mem_en, mem_addr);
         else pass_cnt++;
         @(negedge clk);
         total_cnt++;
         if (rsp_valid !== 1'b1 || rsp_instr !== b_word((i == 0) ? 1 : 0) || rsp_err !== 1'b0)
            $display("FAIL wrap_rsp%0d got v=%b instr=%h err=%b want 1/%h/0",
                     i, rsp_valid, rsp_instr, rsp_err, b_word((i == 0) ? 1 : 0));
         else pass_cnt++;
`endif
      end
      fetch_valid = 1'b1; fetch_addr = 32'h8;
      @(negedge clk);
      fetch_valid = 1'b0;
      total_cnt++;
      if (rsp_valid !== 1'b1 || rsp_instr !== b_word(2) || rsp_err !== 1'b0)
         $display("FAIL legal_rsp got v=%b instr=%h err=%b want 1/%h/0",
                  rsp_valid, rsp_instr, rsp_err, b_word(2));
      else pass_cnt++;
   endtask

   initial begin
      mem_rdata = '0;
      @(negedge clk);
      test_reset();
      test_load4();
      test_back_to_back();
      test_fetch_then_load();
      test_restart();
      test_load64();
      test_addr_check();
      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
